// File: rtl/uart_tx_if.sv
// ----------------------------------------------------------------------------
// uart_tx_if
// Byte handshake between on-chip logic and the UART transmitter.
//   tx_data  : byte to send (producer -> transmitter)
//   tx_valid : tx_data is valid (producer -> transmitter)
//   tx_ready : holding buffer empty, byte will be taken (transmitter -> producer)
// A byte moves on a rising clk edge where tx_valid && tx_ready.
// ----------------------------------------------------------------------------
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // Producer side (on-chip logic / testbench)
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  // Transmitter side
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx
// 8N1 UART transmitter. Takes bytes over a valid/ready handshake into a
// one-byte holding buffer and serialises them LSB-first on tx, one start bit
// (0), eight data bits, one stop bit (1), TICKS_PER_BIT clocks per bit.
// A byte waiting in the buffer when a stop bit ends starts immediately, so
// consecutive frames have no idle gap.
//
// Ports:
//   clk      : system clock, single rising-edge domain
//   reset    : asynchronous, active-high reset
//   tx_if    : byte handshake (uart_tx_if.slave: tx_data, tx_valid, tx_ready)
//   cts      : clear-to-send from far end, active-low, asynchronous to clk
//   tx       : serial output, idle high, registered
//   busy     : high from first start-bit clock to last stop-bit clock
//   tx_done  : one-clock pulse on the last clock of each stop bit
//
// Build option:
//   UART_TX_CTS_FLOW_EN - when defined, cts is synchronised (two flops) and a
//   new frame only starts while synchronised cts is low. The decision is taken
//   only at frame start; a running frame always completes. When undefined,
//   cts is ignored and frames start as soon as a byte is buffered.
// ----------------------------------------------------------------------------
module uart_tx #(
  parameter int BAUD_RATE     = 115200,
  parameter int CLK_FREQ      = 12000000,
  parameter int TICKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave tx_if,
  input  logic     cts,
  output logic     tx,
  output logic     busy,
  output logic     tx_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Last count of a bit period, and the one before it (where tx_done is set
  // so that the registered pulse lands on the final stop-bit clock).
  localparam logic [31:0] TICK_LAST_C   = 32'(TICKS_PER_BIT - 1);
  localparam logic [31:0] TICK_PENULT_C = 32'(TICKS_PER_BIT - 2);

  state_t      state_r;
  logic [31:0] baud_cnt_r;
  logic [2:0]  bit_idx_r;
  logic [7:0]  shift_r;
  logic [7:0]  buf_r;
  logic        buf_full_r;
  logic        tx_r;
  logic        busy_r;
  logic        tx_done_r;

  logic        send_ok_s;
  logic        frame_edge_s;
  logic        load_s;
  logic        accept_s;

`ifdef UART_TX_CTS_FLOW_EN
  logic cts_meta_r;
  logic cts_sync_r;

  // Two-flop synchroniser for cts; resets to "not clear" (high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cts_meta_r <= 1'b1;
      cts_sync_r <= 1'b1;
    end else begin
      cts_meta_r <= cts;
      cts_sync_r <= cts_meta_r;
    end
  end

  assign send_ok_s = ~cts_sync_r;
`else
  // cts has no function in this build; tie it off.
  logic unused_cts_s;
  assign unused_cts_s = cts;
  assign send_ok_s    = 1'b1;
`endif

  // Frame-start decision and handshake acceptance.
  always_comb begin
    frame_edge_s = 1'b0;
    if (state_r == ST_IDLE) begin
      frame_edge_s = 1'b1;
    end else if ((state_r == ST_STOP) && (baud_cnt_r == TICK_LAST_C)) begin
      frame_edge_s = 1'b1;
    end else begin
      frame_edge_s = 1'b0;
    end
    // Load needs a full buffer and accept needs an empty one, so both can
    // never happen on the same edge: the buffer is never overwritten.
    load_s   = buf_full_r & send_ok_s & frame_edge_s;
    accept_s = tx_if.tx_valid & ~buf_full_r;
  end

  assign tx_if.tx_ready = ~buf_full_r;
  assign tx             = tx_r;
  assign busy           = busy_r;
  assign tx_done        = tx_done_r;

  // Holding buffer, frame state machine, baud counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= 32'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
      buf_r      <= 8'd0;
      buf_full_r <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;

      if (accept_s) begin
        buf_r      <= tx_if.tx_data;
        buf_full_r <= 1'b1;
      end else if (load_s) begin
        buf_full_r <= 1'b0;
      end else begin
        buf_full_r <= buf_full_r;
      end

      case (state_r)
        ST_IDLE: begin
          baud_cnt_r <= 32'd0;
          if (load_s) begin
            shift_r <= buf_r;
            state_r <= ST_START;
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
        end

        ST_START: begin
          if (baud_cnt_r == TICK_LAST_C) begin
            baud_cnt_r <= 32'd0;
            bit_idx_r  <= 3'd0;
            state_r    <= ST_DATA;
            tx_r       <= shift_r[0];
          end else begin
            baud_cnt_r <= baud_cnt_r + 32'd1;
          end
        end

        ST_DATA: begin
          if (baud_cnt_r == TICK_LAST_C) begin
            baud_cnt_r <= 32'd0;
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx_r      <= shift_r[bit_idx_r + 3'd1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 32'd1;
          end
        end

        ST_STOP: begin
          if (baud_cnt_r == TICK_LAST_C) begin
            baud_cnt_r <= 32'd0;
            if (load_s) begin
              // Back-to-back: next start bit follows with no idle clock.
              shift_r <= buf_r;
              state_r <= ST_START;
              tx_r    <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
              tx_r    <= 1'b1;
              busy_r  <= 1'b0;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 32'd1;
            if (baud_cnt_r == TICK_PENULT_C) begin
              tx_done_r <= 1'b1;
            end else begin
              tx_done_r <= 1'b0;
            end
          end
        end

        default: begin
          state_r    <= ST_IDLE;
          baud_cnt_r <= 32'd0;
          tx_r       <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx at default parameters (104 clocks per bit).
// The expected line is computed from the frame rules: bit period b = k / 104
// within a frame, b=0 start (0), b=1..8 data LSB-first, b=9 stop (1). A line
// decoder samples tx mid-bit and rebuilds bytes independently of the DUT's
// busy/done outputs. Build with +define+UART_TX_CTS_FLOW_EN to add the
// flow-control scenario.
// ----------------------------------------------------------------------------
module tb_uart_tx;
  localparam int T     = 104;
  localparam int FRAME = 10 * T;

  logic clk = 1'b0;
  logic reset;
  logic cts;
  logic tx;
  logic busy;
  logic tx_done;

  uart_tx_if bus();

  uart_tx dut (
    .clk     (clk),
    .reset   (reset),
    .tx_if   (bus),
    .cts     (cts),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Line monitor results
  logic [7:0] dec_q[$];
  int         span_q[$];
  int         dec_err  = 0;
  int         done_cnt = 0;

  // Expected tx level at clock k (0-based) of a frame carrying byte b.
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int bi;
    bi = k / T;
    if (bi == 0) return 1'b0;
    else if (bi <= 8) return b[bi-1];
    else return 1'b1;
  endfunction

  // Line decoder, tx_done counter and busy-span recorder.
  initial begin : line_monitor
    bit         active;
    bit         frame_ok;
    int         cnt;
    int         run;
    int         bi;
    logic [7:0] sh;
    active = 0; frame_ok = 1; cnt = 0; run = 0; sh = 8'h00;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        active = 0;
        run    = 0;
      end else begin
        if (tx_done === 1'b1) done_cnt++;
        if (busy === 1'b1) run++;
        else if (run > 0) begin
          span_q.push_back(run);
          run = 0;
        end
        if (!active) begin
          if (tx === 1'b0) begin
            active = 1; cnt = 0; frame_ok = 1;
          end
        end else begin
          cnt++;
        end
        if (active && ((cnt % T) == T / 2)) begin
          bi = cnt / T;
          if (bi == 0) begin
            if (tx !== 1'b0) frame_ok = 0;
          end else if (bi <= 8) begin
            sh[bi-1] = tx;
          end else begin
            if (tx !== 1'b1 || !frame_ok) dec_err++;
            else dec_q.push_back(sh);
            active = 0;
          end
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, output bit ok);
    int g;
    bit acc;
    g = 0; acc = 0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (!acc && g < 3 * FRAME) begin
      acc = bus.tx_ready;
      @(negedge clk);
      g++;
    end
    bus.tx_valid = 1'b0;
    ok = acc;
  endtask

  task automatic wait_idle(output bit ok);
    int g;
    g = 0; ok = 0;
    while (g < 4 * FRAME) begin
      @(negedge clk);
      g++;
      if (busy === 1'b0 && bus.tx_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int d0;
    reset = 1'b1; cts = 1'b0;
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    tests++;
    if ({tx, busy, tx_done, bus.tx_ready} !== 4'b1001) begin
      fails++;
      $display("FAIL reset_values: got %b want 1001", {tx, busy, tx_done, bus.tx_ready});
    end
    reset = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      tests++;
      if ({tx, busy, tx_done, bus.tx_ready} !== 4'b1001) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d: got %b want 1001", i, {tx, busy, tx_done, bus.tx_ready});
      end
    end
    tests++;
    if (done_cnt - d0 !== 0) begin
      fails++;
      $display("FAIL reset_no_done: got %0d pulses want 0", done_cnt - d0);
    end
  endtask

  task automatic test_single(input logic [7:0] b);
    int d0;
    logic [2:0] exp;
    d0 = done_cnt;
    dec_q.delete();
    span_q.delete();
    bus.tx_data = b; bus.tx_valid = 1'b1;
    @(negedge clk);                      // accepted on this edge
    bus.tx_valid = 1'b0; bus.tx_data = 8'($urandom);
    tests++;
    if ({tx, bus.tx_ready} !== 2'b10) begin
      fails++;
      $display("FAIL single_accept: got tx,ready=%b want 10", {tx, bus.tx_ready});
    end
    for (int k = 0; k <= FRAME; k++) begin
      @(negedge clk);
      exp = (k < FRAME) ? {exp_tx(b, k), 1'b1, (k == FRAME - 1)} : 3'b100;
      tests++;
      if ({tx, busy, tx_done} !== exp) begin
        fails++;
        $display("FAIL single_wave byte=%h k=%0d: got %b want %b", b, k, {tx, busy, tx_done}, exp);
      end
      if (k == 0) begin
        tests++;
        if (bus.tx_ready !== 1'b1) begin
          fails++;
          $display("FAIL single_ready_recover: got %b want 1", bus.tx_ready);
        end
      end
    end
    tests++;
    if (dec_q.size() != 1 || dec_q[0] !== b) begin
      fails++;
      $display("FAIL single_decode: got %0d bytes first=%h want 1 byte %h", dec_q.size(), (dec_q.size() > 0) ? dec_q[0] : 8'h00, b);
    end
    tests++;
    if (done_cnt - d0 !== 1 || span_q.size() != 1 || span_q[0] != FRAME) begin
      fails++;
      $display("FAIL single_done_span: got done=%0d spans=%0d want done=1 span=%0d", done_cnt - d0, span_q.size(), FRAME);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    bit pend;
    logic [2:0] exp;
    logic [7:0] b0, b1;
    b0 = 8'hA3; b1 = 8'h0F; pend = 0;
    d0 = done_cnt;
    dec_q.delete();
    span_q.delete();
    bus.tx_data = b0; bus.tx_valid = 1'b1;
    @(negedge clk);                      // b0 accepted
    bus.tx_data = b1;                    // valid stays high until b1 is taken
    for (int k = 0; k <= 2 * FRAME; k++) begin
      @(negedge clk);
      if (pend) begin
        bus.tx_valid = 1'b0; pend = 0;
      end else if (bus.tx_valid && bus.tx_ready) begin
        pend = 1;
      end
      if (k < FRAME) exp = {exp_tx(b0, k), 1'b1, (k == FRAME - 1)};
      else if (k < 2 * FRAME) exp = {exp_tx(b1, k - FRAME), 1'b1, (k == 2 * FRAME - 1)};
      else exp = 3'b100;
      tests++;
      if ({tx, busy, tx_done} !== exp) begin
        fails++;
        $display("FAIL b2b_wave k=%0d: got %b want %b", k, {tx, busy, tx_done}, exp);
      end
    end
    bus.tx_valid = 1'b0;
    tests++;
    if (dec_q.size() != 2 || dec_q[0] !== b0 || dec_q[1] !== b1) begin
      fails++;
      $display("FAIL b2b_decode: got %0d bytes want a3 0f", dec_q.size());
    end
    tests++;
    if (done_cnt - d0 !== 2 || span_q.size() != 1 || span_q[0] != 2 * FRAME) begin
      fails++;
      $display("FAIL b2b_span: got done=%0d spans=%0d want done=2 one span of %0d", done_cnt - d0, span_q.size(), 2 * FRAME);
    end
  endtask

  task automatic test_hold_off();
    int d0;
    bit ok1, ok2, oki;
    logic [7:0] b1, b2;
    b1 = 8'($urandom); b2 = 8'($urandom);
    d0 = done_cnt;
    dec_q.delete();
    push_byte(b1, ok1);
    push_byte(b2, ok2);
    tests++;
    if (!(ok1 && ok2)) begin
      fails++;
      $display("FAIL hold_accept: got ok=%0d%0d want 11", ok1, ok2);
    end
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      bus.tx_data = 8'($urandom);
      @(negedge clk);
      tests++;
      if (bus.tx_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_ready cyc=%0d: got %b want 0", i, bus.tx_ready);
      end
    end
    bus.tx_valid = 1'b0;
    wait_idle(oki);
    tests++;
    if (!oki) begin
      fails++;
      $display("FAIL hold_idle_timeout: got busy=%b ready=%b want 0 1", busy, bus.tx_ready);
    end
    tests++;
    if (dec_q.size() != 2 || dec_q[0] !== b1 || dec_q[1] !== b2 || done_cnt - d0 !== 2) begin
      fails++;
      $display("FAIL hold_decode: got %0d bytes done=%0d want %h %h done=2", dec_q.size(), done_cnt - d0, b1, b2);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    bit ok1, ok2;
    push_byte(8'hFF, ok1);               // start edge follows; now at k=-1
    push_byte(8'($urandom), ok2);        // buffered; now at k=1
    tests++;
    if (!(ok1 && ok2)) begin
      fails++;
      $display("FAIL rstmid_accept: got ok=%0d%0d want 11", ok1, ok2);
    end
    repeat (5 * T + T / 2 - 1) @(negedge clk);   // middle of data bit 4
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({tx, busy, tx_done, bus.tx_ready} !== 4'b1001) begin
      fails++;
      $display("FAIL rstmid_async: got %b want 1001", {tx, busy, tx_done, bus.tx_ready});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dec_q.delete();
    d0 = done_cnt;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      tests++;
      if ({tx, busy, bus.tx_ready} !== 3'b101) begin
        fails++;
        $display("FAIL rstmid_quiet cyc=%0d: got %b want 101", i, {tx, busy, bus.tx_ready});
      end
    end
    tests++;
    if (dec_q.size() != 0 || done_cnt - d0 !== 0) begin
      fails++;
      $display("FAIL rstmid_no_frames: got %0d bytes done=%0d want 0 0", dec_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int d0;
    bit ok, oki;
    d0 = done_cnt;
    dec_q.delete();
    for (int n = 0; n < 5; n++) begin
      repeat ($urandom_range(0, 1200)) @(negedge clk);
      b = 8'($urandom);
      push_byte(b, ok);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL rand_accept n=%0d: got no accept want accept", n);
      end else begin
        exp_q.push_back(b);
      end
    end
    wait_idle(oki);
    tests++;
    if (!oki) begin
      fails++;
      $display("FAIL rand_idle_timeout: got busy=%b ready=%b want 0 1", busy, bus.tx_ready);
    end
    tests++;
    if (dec_q.size() != exp_q.size() || done_cnt - d0 != exp_q.size() || dec_err != 0) begin
      fails++;
      $display("FAIL rand_count: got %0d bytes done=%0d ferr=%0d want %0d", dec_q.size(), done_cnt - d0, dec_err, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < dec_q.size(); i++) begin
      tests++;
      if (dec_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL rand_byte i=%0d: got %h want %h", i, dec_q[i], exp_q[i]);
      end
    end
  endtask

`ifdef UART_TX_CTS_FLOW_EN
  task automatic test_cts();
    logic [7:0] b;
    logic [2:0] exp;
    b = 8'h41;
    cts = 1'b1;
    repeat (4) @(negedge clk);
    dec_q.delete();
    bus.tx_data = b; bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if ({tx, busy, bus.tx_ready} !== 3'b100) begin
        fails++;
        $display("FAIL cts_hold cyc=%0d: got %b want 100", i, {tx, busy, bus.tx_ready});
      end
    end
    cts = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (tx !== 1'b1) begin
        fails++;
        $display("FAIL cts_latency cyc=%0d: got tx=%b want 1", i, tx);
      end
    end
    for (int k = 0; k <= FRAME; k++) begin
      @(negedge clk);
      if (k == 300) cts = 1'b1;
      exp = (k < FRAME) ? {exp_tx(b, k), 1'b1, (k == FRAME - 1)} : 3'b100;
      tests++;
      if ({tx, busy, tx_done} !== exp) begin
        fails++;
        $display("FAIL cts_wave k=%0d: got %b want %b", k, {tx, busy, tx_done}, exp);
      end
    end
    tests++;
    if (dec_q.size() != 1 || dec_q[0] !== b) begin
      fails++;
      $display("FAIL cts_decode: got %0d bytes want 1 byte 41", dec_q.size());
    end
    cts = 1'b0;
    repeat (4) @(negedge clk);
  endtask
`endif

  initial begin : watchdog
    #(4_000_000);
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_single(8'h55);
    test_back_to_back();
    test_hold_off();
    test_reset_mid();
    test_random();
`ifdef UART_TX_CTS_FLOW_EN
    test_cts();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
